// File: rtl/spi_slave_regfile.sv
// spi_slave_regfile
// SPI mode-0 target with a 16-entry register file. The SPI pins are
// oversampled on pclk_i; frames are <4-bit cmd><4-bit addr><DATA_W data>
// words, MSB first, with auto-incrementing bursts while cs_n stays low.
// Local logic reads the register file combinationally via usr_addr_i.

module spi_slave_regfile #(
   parameter int          DATA_W = 16,
   parameter logic [3:0]  CMD_WR = 4'b1010,
   parameter logic [3:0]  CMD_RD = 4'b1011
) (
   input  logic              pclk_i,
   input  logic              rst_n_i,
   input  logic              spi_clk_i,
   input  logic              spi_cs_n_i,
   input  logic              spi_sdi_i,
   output logic              spi_sdo_o,
   output logic              spi_sdo_oe_o,
   output logic              reg_wr_o,
   output logic [3:0]        reg_addr_o,
   output logic [DATA_W-1:0] reg_wdata_o,
   output logic              frame_err_o,
   input  logic [3:0]        usr_addr_i,
   output logic [DATA_W-1:0] usr_rdata_o
);

   localparam int                CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0]  LAST_HDR = CNT_W'(3);

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      DATA,
      IGNORE
   } state_t;

   // Pin synchronizers and edge-detect taps
   logic clk_s1, clk_s2, clk_s3;
   logic cs_s1, cs_s2, cs_s3;
   logic sdi_s1, sdi_s2;

   logic clk_rise, clk_fall, cs_fall, cs_rise;

   // FSM and datapath state
   state_t              state, state_nxt;
   logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
   logic [2:0]          cmd_sh, cmd_sh_nxt;
   logic [3:0]          addr, addr_nxt;
   logic                is_rd, is_rd_nxt;
   logic [DATA_W-2:0]   rx_sh, rx_sh_nxt;
   logic [DATA_W-1:0]   tx_sh, tx_sh_nxt;
   logic                commit;
   logic                frame_err_nxt;

   logic [3:0]          cmd_word;
   logic [3:0]          addr_word;
   logic [DATA_W-1:0]   rx_word;

   logic [DATA_W-1:0]   regfile [16];

   // Synchronize the SPI pins into the pclk domain; third tap on clk/cs for edges
   // NOTE: cs taps reset to 0 so releasing reset mid-frame (cs_n already low)
   //       shows no falling edge and the interrupted frame is not resumed.
   always_ff @(posedge pclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         clk_s1 <= 1'b0;
         clk_s2 <= 1'b0;
         clk_s3 <= 1'b0;
         cs_s1  <= 1'b0;
         cs_s2  <= 1'b0;
         cs_s3  <= 1'b0;
         sdi_s1 <= 1'b0;
         sdi_s2 <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make each flop capture the previous
         //       stage's old value, which is what forms the shift chain.
         clk_s1 <= spi_clk_i;
         clk_s2 <= clk_s1;
         clk_s3 <= clk_s2;
         cs_s1  <= spi_cs_n_i;
         cs_s2  <= cs_s1;
         cs_s3  <= cs_s2;
         sdi_s1 <= spi_sdi_i;
         sdi_s2 <= sdi_s1;
      end
   end

   assign clk_rise  =  clk_s2 & ~clk_s3;
   assign clk_fall  = ~clk_s2 &  clk_s3;
   assign cs_fall   = ~cs_s2  &  cs_s3;
   assign cs_rise   =  cs_s2  & ~cs_s3;

   assign cmd_word  = {cmd_sh, sdi_s2};
   assign addr_word = {addr[2:0], sdi_s2};
   assign rx_word   = {rx_sh, sdi_s2};

   // FSM state register
   always_ff @(posedge pclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state, shift-register and strobe decode
   always_comb begin
      // NOTE: every target gets a default before the case so no path can
      //       leave it unassigned and infer a latch.
      state_nxt     = state;
      bit_cnt_nxt   = bit_cnt;
      cmd_sh_nxt    = cmd_sh;
      addr_nxt      = addr;
      is_rd_nxt     = is_rd;
      rx_sh_nxt     = rx_sh;
      tx_sh_nxt     = tx_sh;
      commit        = 1'b0;
      frame_err_nxt = 1'b0;

      if (cs_rise) begin
         // Deselect wins over any simultaneous clock edge; partial words drop.
         state_nxt   = IDLE;
         bit_cnt_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               if (cs_fall) begin
                  state_nxt   = CMD;
                  bit_cnt_nxt = '0;
               end
            end

            CMD: begin
               if (clk_rise) begin
                  cmd_sh_nxt = cmd_word[2:0];
                  if (bit_cnt == LAST_HDR) begin
                     bit_cnt_nxt = '0;
                     if (cmd_word == CMD_WR || cmd_word == CMD_RD) begin
                        state_nxt = ADDR;
                        is_rd_nxt = (cmd_word == CMD_RD);
                     end else begin
                        state_nxt     = IGNORE;
                        frame_err_nxt = 1'b1;
                     end
                  end else begin
                     bit_cnt_nxt = bit_cnt + CNT_W'(1);
                  end
               end
            end

            ADDR: begin
               if (clk_rise) begin
                  addr_nxt = addr_word;
                  if (bit_cnt == LAST_HDR) begin
                     bit_cnt_nxt = '0;
                     state_nxt   = DATA;
                     if (is_rd) begin
                        tx_sh_nxt = regfile[addr_word];
                     end
                  end else begin
                     bit_cnt_nxt = bit_cnt + CNT_W'(1);
                  end
               end
            end

            DATA: begin
               if (is_rd) begin
                  // The falling edge right after a load (bit_cnt==0) belongs to
                  // the previous bit, so the freshly loaded MSB is not skipped.
                  if (clk_fall && bit_cnt != '0) begin
                     tx_sh_nxt = {tx_sh[DATA_W-2:0], 1'b0};
                  end
                  if (clk_rise) begin
                     if (bit_cnt == LAST_BIT) begin
                        bit_cnt_nxt = '0;
                        addr_nxt    = addr + 4'd1;
                        tx_sh_nxt   = regfile[addr + 4'd1];
                     end else begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                     end
                  end
               end else begin
                  if (clk_rise) begin
                     rx_sh_nxt = rx_word[DATA_W-2:0];
                     if (bit_cnt == LAST_BIT) begin
                        bit_cnt_nxt = '0;
                        commit      = 1'b1;
                        addr_nxt    = addr + 4'd1;
                     end else begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                     end
                  end
               end
            end

            IGNORE: begin
               // Parked until cs_n deasserts.
            end

            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   // Datapath registers and registered output strobes
   always_ff @(posedge pclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         bit_cnt     <= '0;
         cmd_sh      <= '0;
         addr        <= '0;
         is_rd       <= 1'b0;
         rx_sh       <= '0;
         tx_sh       <= '0;
         reg_wr_o    <= 1'b0;
         reg_addr_o  <= '0;
         reg_wdata_o <= '0;
         frame_err_o <= 1'b0;
      end else begin
         bit_cnt     <= bit_cnt_nxt;
         cmd_sh      <= cmd_sh_nxt;
         addr        <= addr_nxt;
         is_rd       <= is_rd_nxt;
         rx_sh       <= rx_sh_nxt;
         tx_sh       <= tx_sh_nxt;
         reg_wr_o    <= commit;
         frame_err_o <= frame_err_nxt;
         if (commit) begin
            reg_addr_o  <= addr;
            reg_wdata_o <= rx_word;
         end
      end
   end

   // Register file: written in the same cycle reg_wr_o rises
   // NOTE: the storage is reset because every entry must read as zero after
   //       reset; without that requirement it could be left unreset.
   always_ff @(posedge pclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < 16; i++) begin
            regfile[i] <= '0;
         end
      end else if (commit) begin
         regfile[addr] <= rx_word;
      end
   end

   assign spi_sdo_oe_o = (state == DATA) && is_rd;
   assign spi_sdo_o    = spi_sdo_oe_o & tx_sh[DATA_W-1];
   assign usr_rdata_o  = regfile[usr_addr_i];

endmodule

// File: tb/tb_spi_slave_regfile.sv
// tb_spi_slave_regfile
// Directed bench: drives SPI mode-0 frames at pclk/10 and checks the write
// strobes, side-port contents, read-back data, burst wrap, abort and bad
// command handling against hand-computed values.

module tb_spi_slave_regfile;

   localparam int DATA_W = 16;

   logic              pclk;
   logic              rst_n;
   logic              spi_clk;
   logic              spi_cs_n;
   logic              spi_sdi;
   logic              spi_sdo;
   logic              spi_sdo_oe;
   logic              reg_wr;
   logic [3:0]        reg_addr;
   logic [DATA_W-1:0] reg_wdata;
   logic              frame_err;
   logic [3:0]        usr_addr;
   logic [DATA_W-1:0] usr_rdata;

   int checks   = 0;
   int failures = 0;

   // Monitors
   int                wr_cnt     = 0;
   int                err_cnt    = 0;
   int                sdo_hi_cnt = 0;
   logic [3:0]        last_addr  = '0;
   logic [DATA_W-1:0] last_data  = '0;
   logic [DATA_W-1:0] usr_at_wr  = '0;

   spi_slave_regfile #(
      .DATA_W (DATA_W),
      .CMD_WR (4'b1010),
      .CMD_RD (4'b1011)
   ) dut (
      .pclk_i       (pclk),
      .rst_n_i      (rst_n),
      .spi_clk_i    (spi_clk),
      .spi_cs_n_i   (spi_cs_n),
      .spi_sdi_i    (spi_sdi),
      .spi_sdo_o    (spi_sdo),
      .spi_sdo_oe_o (spi_sdo_oe),
      .reg_wr_o     (reg_wr),
      .reg_addr_o   (reg_addr),
      .reg_wdata_o  (reg_wdata),
      .frame_err_o  (frame_err),
      .usr_addr_i   (usr_addr),
      .usr_rdata_o  (usr_rdata)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // Count strobes away from the active edge
   always @(negedge pclk) begin
      if (reg_wr === 1'b1) begin
         wr_cnt++;
         last_addr = reg_addr;
         last_data = reg_wdata;
         usr_at_wr = usr_rdata;
      end
      if (frame_err === 1'b1) err_cnt++;
      if (spi_sdo !== 1'b0) sdo_hi_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic spi_half();
      repeat (5) @(negedge pclk);
   endtask

   // One mode-0 bit: set data with clk low, sample sdo just before the rise
   task automatic send_bit(input logic b, output logic s, output logic oe);
      spi_sdi = b;
      spi_half();
      s  = spi_sdo;
      oe = spi_sdo_oe;
      spi_clk = 1'b1;
      spi_half();
      spi_clk = 1'b0;
   endtask

   // Full frame: 4-bit cmd, 4-bit addr, nbits of data (MSB first)
   task automatic spi_xfer(input logic [3:0] cmd, input logic [3:0] addr,
                           input logic [31:0] data, input int nbits,
                           output logic [31:0] rd, output int oe_n);
      logic s, oe;
      rd   = '0;
      oe_n = 0;
      spi_cs_n = 1'b0;
      spi_half();
      for (int i = 0; i < 4; i++) begin
         send_bit(cmd[3-i], s, oe);
         if (oe) oe_n++;
      end
      for (int i = 0; i < 4; i++) begin
         send_bit(addr[3-i], s, oe);
         if (oe) oe_n++;
      end
      for (int i = 0; i < nbits; i++) begin
         send_bit(data[nbits-1-i], s, oe);
         rd = {rd[30:0], s};
         if (oe) oe_n++;
      end
      spi_half();
      spi_cs_n = 1'b1;
      repeat (10) @(negedge pclk);
   endtask

   initial begin
      logic [31:0] rd;
      int          oe_n;
      int          wr0;

      rst_n    = 1'b0;
      spi_clk  = 1'b0;
      spi_cs_n = 1'b1;
      spi_sdi  = 1'b0;
      usr_addr = 4'd0;

      // Reset
      repeat (5) @(negedge pclk);
      rst_n = 1'b1;
      repeat (10) @(negedge pclk);
      check("rst_sdo",       spi_sdo,    0);
      check("rst_oe",        spi_sdo_oe, 0);
      check("rst_reg_wr",    reg_wr,     0);
      check("rst_reg_addr",  reg_addr,   0);
      check("rst_reg_wdata", reg_wdata,  0);
      check("rst_frame_err", frame_err,  0);
      for (int a = 0; a < 16; a++) begin
         usr_addr = 4'(a);
         #1;
         check($sformatf("rst_reg%0d", a), usr_rdata, 0);
      end

      // Single write of 0xA001 to address 11
      usr_addr = 4'hB;
      wr0 = wr_cnt;
      spi_xfer(4'b1010, 4'b1011, 32'h0000_A001, 16, rd, oe_n);
      check("wr_pulses",    wr_cnt - wr0, 1);
      check("wr_addr",      last_addr,    4'hB);
      check("wr_data",      last_data,    16'hA001);
      check("wr_usr_same",  usr_at_wr,    16'hA001);
      check("wr_reg11",     usr_rdata,    16'hA001);
      check("wr_oe_bits",   oe_n,         0);

      // Read back address 11
      wr0 = wr_cnt;
      spi_xfer(4'b1011, 4'b1011, 32'h0, 16, rd, oe_n);
      check("rd_data",      rd[15:0],     16'hA001);
      check("rd_oe_bits",   oe_n,         16);
      check("rd_oe_after",  spi_sdo_oe,   0);
      check("rd_no_wr",     wr_cnt - wr0, 0);

      // Burst write wrapping 15 -> 0
      wr0 = wr_cnt;
      spi_xfer(4'b1010, 4'hF, 32'h1234_5678, 32, rd, oe_n);
      check("burst_pulses", wr_cnt - wr0, 2);
      check("burst_last_a", last_addr,    4'h0);
      usr_addr = 4'hF;
      #1;
      check("burst_reg15",  usr_rdata,    16'h1234);
      usr_addr = 4'h0;
      #1;
      check("burst_reg0",   usr_rdata,    16'h5678);

      // Burst read wrapping 15 -> 0
      spi_xfer(4'b1011, 4'hF, 32'h0, 32, rd, oe_n);
      check("burst_rd",     rd,           32'h1234_5678);
      check("burst_rd_oe",  oe_n,         32);

      // Abort a write to address 3 after 9 data bits
      usr_addr = 4'h3;
      wr0 = wr_cnt;
      spi_xfer(4'b1010, 4'h3, 32'h0000_01FF, 9, rd, oe_n);
      #1;
      check("abort_no_wr",  wr_cnt - wr0, 0);
      check("abort_reg3",   usr_rdata,    16'h0000);

      // Full write of 0xBEEF to address 3
      wr0 = wr_cnt;
      spi_xfer(4'b1010, 4'h3, 32'h0000_BEEF, 16, rd, oe_n);
      check("rewr_pulses",  wr_cnt - wr0, 1);
      check("rewr_addr",    last_addr,    4'h3);
      check("rewr_reg3",    usr_rdata,    16'hBEEF);

      // Bad command followed by 20 clocks
      wr0 = wr_cnt;
      sdo_hi_cnt = 0;
      err_cnt = 0;
      spi_xfer(4'b0101, 4'hF, 32'h0000_FFFF, 16, rd, oe_n);
      check("bad_err_pulse", err_cnt,      1);
      check("bad_no_wr",     wr_cnt - wr0, 0);
      check("bad_sdo_low",   sdo_hi_cnt,   0);
      check("bad_sdo_rd",    rd[15:0],     16'h0000);
      check("bad_oe_bits",   oe_n,         0);

      // Next valid frame decodes normally
      spi_xfer(4'b1011, 4'h3, 32'h0, 16, rd, oe_n);
      check("post_bad_rd",   rd[15:0],     16'hBEEF);
      check("post_bad_err",  err_cnt,      1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
